gost89_ecb_sequencer: RTL

GOST89_ECB_SEQUENCER -- requirements
Module: gost89_ecb_sequencer

---
 rtl/gost89_pkg.sv | 17 +
 rtl/gost89_fifo2.sv | 60 ++++++
 rtl/gost89_ecb_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/gost89_pkg.sv
// Shared types and constants for the GOST 28147-89 ECB block sequencer.
package gost89_pkg;

    localparam int BLOCK_W       = 64;
    localparam int COUNT_W       = 16;
    localparam int FIFO_DEPTH    = 2;
    localparam int START_TIMEOUT = 4;
    localparam int TIMEOUT_W     = $clog2(START_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        RUN
    } seq_state_e;

endpackage

// File: rtl/gost89_fifo2.sv
// Two-entry result FIFO; head is always visible on pop_data.
module gost89_fifo2
    import gost89_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [BLOCK_W-1:0] push_data,
    input  logic               pop,
    output logic [BLOCK_W-1:0] pop_data,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [BLOCK_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage is cleared on reset because the head is a visible
            // output that must read zero after reset; an internal-only RAM would not need it.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so the order of these statements does not matter.
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gost89_ecb_sequencer.sv
// Feeds 64-bit blocks one at a time through an external GOST 28147-89 ECB core
// and queues the results in a two-entry output FIFO.
module gost89_ecb_sequencer
    import gost89_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               core_load,
    output logic [BLOCK_W-1:0] core_in,
    input  logic [BLOCK_W-1:0] core_out,
    input  logic               core_busy,
    output logic               error,
    output logic [COUNT_W-1:0] blocks_done
);
    seq_state_e           state;
    seq_state_e           next_state;
    logic [TIMEOUT_W-1:0] start_cnt;
    logic [COUNT_W-1:0]   done_cnt;
    logic                 accept;
    logic                 timeout;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Only accept a block when idle and the FIFO can still take its result,
    // so a finished block never has to wait for room.
    assign in_ready    = (state == IDLE) && !fifo_full;
    assign accept      = in_valid && in_ready;
    assign core_load   = (state == LOAD);
    assign out_valid   = !fifo_empty;
    assign fifo_pop    = out_valid && out_ready;
    assign blocks_done = done_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the push and timeout strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned and infers a latch.
        next_state = state;
        fifo_push  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state = START;
            end
            START: begin
                if (core_busy) begin
                    next_state = RUN;
                end else if (start_cnt == TIMEOUT_W'(START_TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (!core_busy) begin
                    fifo_push  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: captured block, start-wait counter, sticky error, result count.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_in   <= '0;
            start_cnt <= '0;
            error     <= 1'b0;
            done_cnt  <= '0;
        end else begin
            if (accept) begin
                core_in <= in_data;
            end
            if (state == START) begin
                start_cnt <= start_cnt + 1'b1;
            end else begin
                start_cnt <= '0;
            end
            if (timeout) begin
                error <= 1'b1;
            end
            if (fifo_push) begin
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end

    gost89_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (core_out),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
